// File: rtl/mps_link_pkg.sv
// Shared types and helpers for the MPS pixel-hit readout link.
// Type codes occupy the top two bits of every LVDS word.
package mps_link_pkg;

    typedef enum logic [1:0] {
        TC_IDLE    = 2'b00,
        TC_HEADER  = 2'b01,
        TC_DATA    = 2'b10,
        TC_TRAILER = 2'b11
    } type_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_TRAILER
    } link_state_e;

    localparam int FRAME_CNT_W  = 16;
    localparam int IDLE_PAT_MAX = 64;

    // Alternating 1010... payload, right-aligned below the two type-code bits.
    function automatic logic [IDLE_PAT_MAX-1:0] idle_pattern(input int width);
        logic [IDLE_PAT_MAX-1:0] pat;
        pat = '0;
        for (int i = 0; i < IDLE_PAT_MAX; i++) begin
            pat[i] = (i < width - 2) && i[0];
        end
        return pat;
    endfunction

endpackage

// File: rtl/mps_hit_fifo.sv
// Hit-word FIFO: synchronous write, combinational head read, separate occupancy counter.
// Writes while full and reads while empty are ignored, so callers may offer freely.
module mps_hit_fifo
    import mps_link_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk3,
    input  logic              sys_reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              do_wr, do_rd;

    assign full      = (occ_q == CNT_W'(DEPTH));
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign rd_data   = mem_q[rd_ptr_q];
    assign do_wr     = wr_en && !full;
    assign do_rd     = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk3 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and counter.
    always_ff @(posedge clk3) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/mps_readout_link.sv
// MPS readout link top: buffers hit words and emits one framed burst per trigger.
//   state      | meaning
//   ST_IDLE    | idle word on the bus, waiting for frame_trig
//   ST_HEADER  | header (frame count) on the bus
//   ST_DATA    | one popped hit word per cycle on the bus
//   ST_TRAILER | trailer (word count K) on the bus; may retrigger directly
module mps_readout_link
    import mps_link_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 16,
    parameter int LVDS_W = 24
) (
    input  logic              clk3,
    input  logic              sys_reset_n,
    input  logic              hit_valid,
    input  logic [DATA_W-1:0] hit_data,
    output logic              hit_ready,
    input  logic              frame_trig,
    output logic              trig_miss,
    output logic [LVDS_W-1:0] lvds_out,
    output logic              lvds_valid,
    output logic              mem_full,
    output logic              mem_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PAY_W = LVDS_W - 2;
    localparam logic [IDLE_PAT_MAX-1:0] IDLE_FULL = idle_pattern(LVDS_W);

    function automatic logic [LVDS_W-1:0] mk_word(input type_code_e tc,
                                                  input logic [PAY_W-1:0] pay);
        return {tc, pay};
    endfunction

    localparam logic [LVDS_W-1:0] IDLE_WORD = mk_word(TC_IDLE, IDLE_FULL[PAY_W-1:0]);

    link_state_e             state_q, state_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic [CNT_W-1:0]        left_q, left_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [LVDS_W-1:0]       lvds_out_q, lvds_out_d;
    logic                    lvds_valid_q, lvds_valid_d;
    logic                    trig_miss_q, trig_miss_d;

    logic                    fifo_pop;
    logic [DATA_W-1:0]       fifo_head;
    logic                    fifo_full, fifo_empty;
    logic [CNT_W-1:0]        fifo_occ;

    mps_hit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk3        (clk3),
        .sys_reset_n (sys_reset_n),
        .wr_en       (hit_valid),
        .wr_data     (hit_data),
        .rd_en       (fifo_pop),
        .rd_data     (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .occupancy   (fifo_occ)
    );

    assign hit_ready  = !fifo_full;
    assign mem_full   = fifo_full;
    assign mem_empty  = fifo_empty;
    assign lvds_out   = lvds_out_q;
    assign lvds_valid = lvds_valid_q;
    assign trig_miss  = trig_miss_q;

    // The output register is loaded with the word belonging to the next state,
    // so the bus shows the header in the cycle right after the trigger edge.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        left_d       = left_q;
        frame_cnt_d  = frame_cnt_q;
        lvds_out_d   = IDLE_WORD;
        lvds_valid_d = 1'b0;
        trig_miss_d  = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE, ST_TRAILER: begin
                if (frame_trig) begin
                    state_d      = ST_HEADER;
                    k_d          = fifo_occ;
                    lvds_out_d   = mk_word(TC_HEADER, PAY_W'(frame_cnt_q));
                    lvds_valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEADER: begin
                trig_miss_d  = frame_trig;
                frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                lvds_valid_d = 1'b1;
                if (k_q != '0) begin
                    state_d    = ST_DATA;
                    fifo_pop   = 1'b1;
                    left_d     = k_q - CNT_W'(1);
                    lvds_out_d = mk_word(TC_DATA, PAY_W'(fifo_head));
                end else begin
                    state_d    = ST_TRAILER;
                    lvds_out_d = mk_word(TC_TRAILER, PAY_W'(k_q));
                end
            end
            ST_DATA: begin
                trig_miss_d  = frame_trig;
                lvds_valid_d = 1'b1;
                if (left_q != '0) begin
                    fifo_pop   = 1'b1;
                    left_d     = left_q - CNT_W'(1);
                    lvds_out_d = mk_word(TC_DATA, PAY_W'(fifo_head));
                end else begin
                    state_d    = ST_TRAILER;
                    lvds_out_d = mk_word(TC_TRAILER, PAY_W'(k_q));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk3 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            left_q       <= '0;
            frame_cnt_q  <= '0;
            lvds_out_q   <= IDLE_WORD;
            lvds_valid_q <= 1'b0;
            trig_miss_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            left_q       <= left_d;
            frame_cnt_q  <= frame_cnt_d;
            lvds_out_q   <= lvds_out_d;
            lvds_valid_q <= lvds_valid_d;
            trig_miss_q  <= trig_miss_d;
        end
    end

endmodule

// File: tb/tb_mps_readout_link.sv
// Randomised and directed bench for mps_readout_link with a timeline scoreboard.
module tb_mps_readout_link;

    localparam int DATA_W = 18;
    localparam int DEPTH  = 16;
    localparam int LVDS_W = 24;
    localparam logic [23:0] IDLE_W = 24'h2AAAAA;

    logic              clk3 = 1'b0;
    logic              sys_reset_n = 1'b1;
    logic              hit_valid = 1'b0;
    logic [DATA_W-1:0] hit_data = '0;
    logic              frame_trig = 1'b0;
    logic              hit_ready, trig_miss, lvds_valid, mem_full, mem_empty;
    logic [LVDS_W-1:0] lvds_out;

    mps_readout_link #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVDS_W (LVDS_W)
    ) dut (
        .clk3        (clk3),
        .sys_reset_n (sys_reset_n),
        .hit_valid   (hit_valid),
        .hit_data    (hit_data),
        .hit_ready   (hit_ready),
        .frame_trig  (frame_trig),
        .trig_miss   (trig_miss),
        .lvds_out    (lvds_out),
        .lvds_valid  (lvds_valid),
        .mem_full    (mem_full),
        .mem_empty   (mem_empty)
    );

    always #5 clk3 = ~clk3;

    // Reference model: expected bus words keyed by the cycle they must appear in.
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_word [int];
    bit          miss_at [int];
    logic [17:0] mq [$];
    int          m_occ = 0;
    logic [15:0] m_fcnt = 16'h0000;
    int          busy_until = 0;
    int          pop_from = 1;
    int          pop_to = 0;
    bit          acc_last = 1'b0;
    int          mk;
    bit          mwr, mpop;

    always @(posedge clk3) begin
        cyc++;
        if (!sys_reset_n) begin
            exp_word.delete();
            miss_at.delete();
            mq.delete();
            m_occ      = 0;
            m_fcnt     = 16'h0000;
            busy_until = 0;
            pop_from   = 1;
            pop_to     = 0;
            acc_last   = 1'b0;
        end else begin
            mwr  = hit_valid && (m_occ < DEPTH);
            mpop = (cyc >= pop_from) && (cyc <= pop_to);
            if (frame_trig) begin
                if (cyc >= busy_until) begin
                    mk = m_occ;
                    exp_word[cyc] = 24'h400000 | 24'(m_fcnt);
                    for (int i = 0; i < mk; i++) begin
                        exp_word[cyc + 1 + i] = 24'h800000 | 24'(mq.pop_front());
                    end
                    exp_word[cyc + 1 + mk] = 24'hC00000 | 24'(mk);
                    m_fcnt++;
                    busy_until = cyc + mk + 2;
                    pop_from   = cyc + 1;
                    pop_to     = cyc + mk;
                end else begin
                    miss_at[cyc] = 1'b1;
                end
            end
            if (mwr) mq.push_back(hit_data);
            m_occ    = m_occ + int'(mwr) - int'(mpop);
            acc_last = mwr;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    logic        ev, em;
    logic [23:0] ew;

    always @(negedge clk3 or negedge sys_reset_n) begin
        #1;
        if (!sys_reset_n) begin
            chk("rst_lvds_out", 32'(lvds_out), 32'(IDLE_W));
            chk("rst_lvds_valid", 32'(lvds_valid), 32'd0);
            chk("rst_trig_miss", 32'(trig_miss), 32'd0);
            chk("rst_mem_empty", 32'(mem_empty), 32'd1);
            chk("rst_mem_full", 32'(mem_full), 32'd0);
            chk("rst_hit_ready", 32'(hit_ready), 32'd1);
        end else begin
            if (exp_word.exists(cyc)) begin
                ev = 1'b1;
                ew = exp_word[cyc];
            end else begin
                ev = 1'b0;
                ew = IDLE_W;
            end
            em = miss_at.exists(cyc);
            chk("lvds_valid", 32'(lvds_valid), 32'(ev));
            chk("lvds_out", 32'(lvds_out), 32'(ew));
            chk("trig_miss", 32'(trig_miss), 32'(em));
            chk("mem_full", 32'(mem_full), 32'(m_occ == DEPTH));
            chk("mem_empty", 32'(mem_empty), 32'(m_occ == 0));
            chk("hit_ready", 32'(hit_ready), 32'(m_occ != DEPTH));
        end
    end

    task automatic cyc_drive(input logic v, input logic [17:0] d, input logic t);
        hit_valid  = v;
        hit_data   = d;
        frame_trig = t;
        @(negedge clk3);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, 18'h0, 1'b0);
    endtask

    task automatic push_word(input logic [17:0] d, input logic t);
        int n;
        n = 0;
        cyc_drive(1'b1, d, t);
        while (!acc_last) begin
            if (n == 200) begin
                $display("FAIL push_word timeout: word %0h never accepted, hit_ready %0b", d, hit_ready);
                $fatal(1, "stimulus stalled");
            end
            cyc_drive(1'b1, d, 1'b0);
            n++;
        end
    endtask

    logic        rv;
    logic [17:0] rd;

    initial begin
        #2 sys_reset_n = 1'b0;
        @(negedge clk3);
        @(negedge clk3);
        sys_reset_n = 1'b1;
        idle(5);

        // basic three-word frame, then an empty frame
        push_word(18'h00001, 1'b0);
        push_word(18'h00002, 1'b0);
        push_word(18'h00003, 1'b0);
        cyc_drive(1'b0, 18'h0, 1'b1);
        idle(10);
        cyc_drive(1'b0, 18'h0, 1'b1);
        idle(6);

        // fill to full, hold a 17th word across a full-FIFO trigger
        for (int i = 0; i < DEPTH; i++) push_word(18'h00100 + 18'(i), 1'b0);
        repeat (3) cyc_drive(1'b1, 18'h3ABCD, 1'b0);
        push_word(18'h3ABCD, 1'b1);
        idle(25);
        cyc_drive(1'b0, 18'h0, 1'b1);
        idle(8);

        // write on trigger edge, trigger in DATA, back-to-back from TRAILER
        push_word(18'h00011, 1'b0);
        push_word(18'h00012, 1'b0);
        push_word(18'h00013, 1'b1);
        idle(1);
        cyc_drive(1'b0, 18'h0, 1'b1);
        idle(1);
        cyc_drive(1'b0, 18'h0, 1'b1);
        idle(8);

        // reset during the second data word
        for (int i = 0; i < 4; i++) push_word(18'h00020 + 18'(i), 1'b0);
        cyc_drive(1'b0, 18'h0, 1'b1);
        idle(2);
        #2 sys_reset_n = 1'b0;
        hit_valid  = 1'b0;
        frame_trig = 1'b0;
        @(negedge clk3);
        @(negedge clk3);
        sys_reset_n = 1'b1;
        idle(2);
        cyc_drive(1'b0, 18'h0, 1'b1);
        idle(5);

        // random traffic with upstream holding data while not accepted
        for (int i = 0; i < 1000; i++) begin
            if (hit_valid && !acc_last) begin
                rv = 1'b1;
                rd = hit_data;
            end else begin
                rv = ($urandom_range(0, 2) != 0);
                rd = 18'($urandom);
            end
            cyc_drive(rv, rd, ($urandom_range(0, 19) == 0));
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
